controlador_de_acesso_veicular: RTL and testbench

CONTROLADOR_DE_ACESSO_VEICULAR -- requirements
Module: controlador_de_acesso_veicular

---
 rtl/controlador_de_acesso_veicular_pkg.sv | 13 +
 rtl/controlador_de_acesso_veicular_temporizador.sv | 18 +
 rtl/controlador_de_acesso_veicular.sv | 75 +++++++
 tb/tb_controlador_de_acesso_veicular.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/controlador_de_acesso_veicular_pkg.sv
// controlador_de_acesso_veicular_pkg: state encoding and default timing shared by the access-system blocks
package controlador_de_acesso_veicular_pkg;
  typedef enum logic [2:0] {
    OCIOSO,
    AGUARDANDO_SENHA,
    LIMPAR_SENHA,
    CANCELA_ABERTA,
    BLOQUEADO
  } estado_t;
  localparam int MAX_TENTATIVAS_PADRAO = 3;
  localparam int TEMPO_ABERTA_PADRAO = 50;
  localparam int TEMPO_BLOQUEIO_PADRAO = 100;
endpackage

// File: rtl/controlador_de_acesso_veicular_temporizador.sv
// temporizador_de_acesso: loadable down-counter that stops at zero
module temporizador_de_acesso #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] valor,
  output logic [W-1:0] contagem,
  output logic         zero
);
  assign zero = contagem == '0;
  always_ff @(posedge clk)
    if (rst) contagem <= '0;
    else if (load) contagem <= valor;
    else if (en && !zero) contagem <= contagem - W'(1);
endmodule

// File: rtl/controlador_de_acesso_veicular.sv
// controlador_de_acesso_veicular: vehicle gate controller with password check, lockout and hold timers
module controlador_de_acesso_veicular
  import controlador_de_acesso_veicular_pkg::*;
#(
  parameter int MAX_TENTATIVAS = MAX_TENTATIVAS_PADRAO,
  parameter int TEMPO_ABERTA   = TEMPO_ABERTA_PADRAO,
  parameter int TEMPO_BLOQUEIO = TEMPO_BLOQUEIO_PADRAO
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       SENSOR_VEICULO,
  input  logic       SENHA_CERTA,
  input  logic       ERRO_SENHA,
  output logic       HABILITAR_SENHA,
  output logic       ABRIR_CANCELA,
  output logic       BLOQUEIO,
  output logic       ALARME,
  output logic [1:0] TENTATIVAS
);
  localparam int W = $clog2((TEMPO_ABERTA > TEMPO_BLOQUEIO ? TEMPO_ABERTA : TEMPO_BLOQUEIO) + 1);
  estado_t estado, proximo;
  logic erro_q, evento, carregar, decrementar, zero, expira, limpar_tent;
  logic [W-1:0] contagem, valor;
  logic [1:0] nova;
  assign evento = estado == AGUARDANDO_SENHA && ERRO_SENHA && !erro_q;
  assign nova = TENTATIVAS == 2'(MAX_TENTATIVAS) ? TENTATIVAS : TENTATIVAS + 2'd1;
  assign decrementar = estado == BLOQUEADO || (estado == CANCELA_ABERTA && !SENSOR_VEICULO);
  // leave on the edge where the count steps from 1 to 0, not one cycle later
  assign expira = zero || (decrementar && contagem == W'(1));
  assign carregar = (proximo == CANCELA_ABERTA && (estado != CANCELA_ABERTA || SENSOR_VEICULO))
                 || (proximo == BLOQUEADO && estado != BLOQUEADO);
  assign valor = proximo == BLOQUEADO ? W'(TEMPO_BLOQUEIO) : W'(TEMPO_ABERTA);
  assign limpar_tent = (proximo == CANCELA_ABERTA && estado != CANCELA_ABERTA)
                    || (estado == BLOQUEADO && proximo != BLOQUEADO);
  always_comb begin
    proximo = estado;
    case (estado)
      OCIOSO:           proximo = SENSOR_VEICULO ? AGUARDANDO_SENHA : OCIOSO;
      AGUARDANDO_SENHA: proximo = evento ? (nova == 2'(MAX_TENTATIVAS) ? BLOQUEADO : LIMPAR_SENHA)
                                : SENHA_CERTA ? CANCELA_ABERTA
                                : !SENSOR_VEICULO ? OCIOSO : AGUARDANDO_SENHA;
      LIMPAR_SENHA:     proximo = SENSOR_VEICULO ? AGUARDANDO_SENHA : OCIOSO;
      CANCELA_ABERTA:   proximo = (!SENSOR_VEICULO && expira) ? OCIOSO : CANCELA_ABERTA;
      BLOQUEADO:        proximo = expira ? OCIOSO : BLOQUEADO;
      default:          proximo = OCIOSO;
    endcase
  end
  always_ff @(posedge CLK)
    if (RESET) begin
      estado <= OCIOSO;
      erro_q <= 1'b0;
      TENTATIVAS <= 2'd0;
      HABILITAR_SENHA <= 1'b0;
      ABRIR_CANCELA <= 1'b0;
      BLOQUEIO <= 1'b0;
      ALARME <= 1'b0;
    end else begin
      estado <= proximo;
      erro_q <= ERRO_SENHA;
      TENTATIVAS <= limpar_tent ? 2'd0 : evento ? nova : TENTATIVAS;
      HABILITAR_SENHA <= proximo == AGUARDANDO_SENHA;
      ABRIR_CANCELA <= proximo == CANCELA_ABERTA;
      BLOQUEIO <= proximo == BLOQUEADO;
      ALARME <= proximo == BLOQUEADO && estado != BLOQUEADO;
    end
  temporizador_de_acesso #(.W(W)) u_temporizador (
    .clk(CLK),
    .rst(RESET),
    .load(carregar),
    .en(decrementar),
    .valor(valor),
    .contagem(contagem),
    .zero(zero)
  );
endmodule

// File: tb/tb_controlador_de_acesso_veicular.sv
// tb_controlador_de_acesso_veicular: directed vectors checked against a cycle model of the gate rules
module tb_controlador_de_acesso_veicular;
  localparam int MAX = 3;
  localparam int T_AB = 4;
  localparam int T_BLOQ = 8;
  logic CLK = 0, RESET = 1, SENSOR_VEICULO = 0, SENHA_CERTA = 0, ERRO_SENHA = 0;
  logic HABILITAR_SENHA, ABRIR_CANCELA, BLOQUEIO, ALARME;
  logic [1:0] TENTATIVAS;
  int comparados = 0, divergentes = 0;
  bit ativo = 0;
  int m_fase = 0, m_rest = 0, m_tent = 0;
  bit m_alarme = 0, m_erro_ant = 0;
  controlador_de_acesso_veicular #(.MAX_TENTATIVAS(MAX), .TEMPO_ABERTA(T_AB), .TEMPO_BLOQUEIO(T_BLOQ)) dut (
    .CLK(CLK),
    .RESET(RESET),
    .SENSOR_VEICULO(SENSOR_VEICULO),
    .SENHA_CERTA(SENHA_CERTA),
    .ERRO_SENHA(ERRO_SENHA),
    .HABILITAR_SENHA(HABILITAR_SENHA),
    .ABRIR_CANCELA(ABRIR_CANCELA),
    .BLOQUEIO(BLOQUEIO),
    .ALARME(ALARME),
    .TENTATIVAS(TENTATIVAS)
  );
  always #5 CLK = ~CLK;
  task automatic verifica(input string nome, input int atual, input int esperado);
    comparados++;
    if (atual != esperado) begin
      divergentes++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", nome, atual, esperado, $time);
    end
  endtask
  // fase: 0 idle, 1 waiting for password, 2 clearing checker, 3 gate open, 4 locked out
  always @(posedge CLK) begin : modelo
    int f, r, t;
    bit a, ev;
    f = m_fase;
    r = m_rest;
    t = m_tent;
    a = 0;
    ev = f == 1 && ERRO_SENHA && !m_erro_ant;
    if (RESET) begin
      f = 0;
      r = 0;
      t = 0;
    end else if (f == 0) f = SENSOR_VEICULO ? 1 : 0;
    else if (f == 1) begin
      if (ev) begin
        t = t < MAX ? t + 1 : t;
        if (t == MAX) begin
          f = 4;
          r = T_BLOQ;
          a = 1;
        end else f = 2;
      end else if (SENHA_CERTA) begin
        f = 3;
        r = T_AB;
        t = 0;
      end else if (!SENSOR_VEICULO) f = 0;
    end else if (f == 2) f = SENSOR_VEICULO ? 1 : 0;
    else if (f == 3) begin
      if (SENSOR_VEICULO) r = T_AB;
      else begin
        r = r - 1;
        if (r == 0) f = 0;
      end
    end else begin
      r = r - 1;
      if (r == 0) begin
        f = 0;
        t = 0;
      end
    end
    m_fase <= f;
    m_rest <= r;
    m_tent <= t;
    m_alarme <= a;
    m_erro_ant <= RESET ? 1'b0 : ERRO_SENHA;
  end
  always @(negedge CLK)
    if (ativo)
      verifica("ciclo{hab,abrir,bloq,alarme,tent}",
               int'({HABILITAR_SENHA, ABRIR_CANCELA, BLOQUEIO, ALARME, TENTATIVAS}),
               int'({m_fase == 1, m_fase == 3, m_fase == 4, m_alarme, 2'(m_tent)}));
  task automatic aplica(input bit s, input bit c, input bit e, input int n);
    SENSOR_VEICULO = s;
    SENHA_CERTA = c;
    ERRO_SENHA = e;
    repeat (n) @(negedge CLK);
  endtask
  task automatic saidas_zeradas(input string nome);
    verifica(nome, int'({HABILITAR_SENHA, ABRIR_CANCELA, BLOQUEIO, ALARME, TENTATIVAS}), 0);
  endtask
  initial begin
    @(negedge CLK);
    aplica(0, 0, 0, 2);
    RESET = 0;
    ativo = 1;
    saidas_zeradas("reset_inicial");
    aplica(0, 1, 1, 2);
    verifica("certa_fora_de_espera", ABRIR_CANCELA, 0);
    aplica(1, 0, 0, 1);
    verifica("espera_hab", HABILITAR_SENHA, 1);
    aplica(1, 1, 0, 1);
    verifica("aberta", ABRIR_CANCELA, 1);
    aplica(1, 0, 0, 3);
    aplica(0, 0, 0, 3);
    verifica("aberta_3_apos_saida", ABRIR_CANCELA, 1);
    aplica(0, 0, 0, 1);
    verifica("fechada_4_apos_saida", ABRIR_CANCELA, 0);
    aplica(1, 0, 0, 1);
    aplica(1, 0, 1, 1);
    verifica("erro1_tent", TENTATIVAS, 1);
    verifica("erro1_hab", HABILITAR_SENHA, 0);
    aplica(1, 0, 0, 1);
    verifica("erro1_volta_hab", HABILITAR_SENHA, 1);
    aplica(1, 0, 1, 1);
    verifica("erro2_tent", TENTATIVAS, 2);
    aplica(1, 0, 0, 1);
    aplica(1, 0, 1, 1);
    verifica("erro3_bloq_alarme", int'({BLOQUEIO, ALARME}), 3);
    verifica("modelo_tent3", m_tent, 3);
    aplica(1, 0, 1, 1);
    verifica("alarme_um_ciclo", ALARME, 0);
    aplica(1, 0, 0, 6);
    verifica("bloq_ciclo8", int'({BLOQUEIO, TENTATIVAS}), 7);
    aplica(1, 0, 0, 1);
    verifica("bloq_fim", int'({BLOQUEIO, TENTATIVAS}), 0);
    aplica(1, 0, 0, 1);
    aplica(1, 0, 1, 1);
    aplica(1, 0, 0, 1);
    aplica(1, 0, 1, 1);
    aplica(0, 0, 0, 1);
    verifica("saida_mantem_tent", TENTATIVAS, 2);
    aplica(0, 0, 0, 2);
    aplica(1, 0, 0, 1);
    aplica(1, 0, 1, 1);
    verifica("volta_bloq_tent3", int'({BLOQUEIO, TENTATIVAS}), 7);
    aplica(1, 0, 0, 2);
    RESET = 1;
    aplica(1, 0, 0, 1);
    RESET = 0;
    saidas_zeradas("reset_em_bloqueado");
    verifica("modelo_reset", m_fase, 0);
    aplica(1, 0, 0, 1);
    aplica(1, 0, 1, 5);
    verifica("erro_mantido_tent", TENTATIVAS, 1);
    verifica("erro_mantido_hab", HABILITAR_SENHA, 1);
    aplica(1, 1, 0, 1);
    verifica("aberta_zera_tent", int'({ABRIR_CANCELA, TENTATIVAS}), 4);
    aplica(1, 0, 0, 2);
    RESET = 1;
    aplica(1, 0, 0, 1);
    RESET = 0;
    saidas_zeradas("reset_em_aberta");
    aplica(1, 0, 0, 1);
    aplica(1, 1, 1, 1);
    verifica("simultaneo_fechada", int'({ABRIR_CANCELA, TENTATIVAS}), 1);
    aplica(1, 0, 0, 1);
    aplica(0, 0, 0, 1);
    aplica(1, 0, 1, 1);
    aplica(1, 0, 1, 2);
    verifica("erro_alto_na_entrada", int'({HABILITAR_SENHA, TENTATIVAS}), 5);
    aplica(0, 0, 0, 3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", comparados, divergentes);
    $finish;
  end
endmodule
